// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// lock-loss counter width and default timing parameters.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    WAIT_IDLY,
    RELEASE,
    RUN,
    FAULT
  } seq_state_t;

  localparam int LOSS_CNT_W       = 8;
  localparam int DEF_HOLD_CYCLES  = 1024;
  localparam int DEF_IDLY_TIMEOUT = 65535;

endpackage

// File: rtl/rst_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Resets to 0 so an unsynchronized input always reads as "not ready".
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release after PLL lock (and optionally IDELAYCTRL ready).
// Optional feature macro: RST_SEQ_IDELAY_WAIT_EN enables the idelay_rdy wait and timeout.
//
// state     | meaning
// WAIT_LOCK | all stages held in reset, waiting for synchronized pll lock
// WAIT_IDLY | locked, waiting for idelay ready with timeout
// RELEASE   | releasing stages one by one every HOLD_CYCLES
// RUN       | all stages released, ready high
// FAULT     | idelay ready timed out; held until lock loss or sw_rst
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int IDLY_TIMEOUT = DEF_IDLY_TIMEOUT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  pll_lock,
  input  logic                  idelay_rdy,
  input  logic                  sw_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic                  idelay_fault,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int K_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [K_W-1:0] LAST_K  = K_W'(NUM_STAGES - 1);
  localparam logic [15:0]    HOLD_TC = 16'(HOLD_CYCLES - 1);

  seq_state_t     state;
  logic [15:0]    cnt;
  logic [K_W-1:0] k;
  logic           lock_s;
  logic           lock_loss;

  sync_2ff u_sync_lock (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

`ifdef RST_SEQ_IDELAY_WAIT_EN
  localparam logic [15:0] IDLY_TC = 16'(IDLY_TIMEOUT - 1);
  logic idly_s;
  logic fault_r;

  sync_2ff u_sync_idly (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (idelay_rdy),
    .q     (idly_s)
  );

  assign idelay_fault = fault_r;
`else
  logic unused_idelay_rdy;
  assign unused_idelay_rdy = idelay_rdy;
  assign idelay_fault      = 1'b0;
`endif

  assign lock_loss = !lock_s && (state != WAIT_LOCK);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      k             <= '0;
      rst_out       <= '1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
`ifdef RST_SEQ_IDELAY_WAIT_EN
      fault_r       <= 1'b0;
`endif
    end else if (sw_rst || lock_loss) begin
      // Abort has priority over any terminal count in the same cycle.
      state   <= WAIT_LOCK;
      cnt     <= '0;
      k       <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      if (lock_loss && (lock_loss_cnt != '1))
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
`ifdef RST_SEQ_IDELAY_WAIT_EN
      if (sw_rst)
        fault_r <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT_LOCK: begin
          rst_out <= '1;
          ready   <= 1'b0;
          if (lock_s) begin
            cnt <= '0;
            k   <= '0;
`ifdef RST_SEQ_IDELAY_WAIT_EN
            state <= WAIT_IDLY;
`else
            state <= RELEASE;
`endif
          end
        end
`ifdef RST_SEQ_IDELAY_WAIT_EN
        WAIT_IDLY: begin
          if (idly_s) begin
            cnt   <= '0;
            k     <= '0;
            state <= RELEASE;
          end else if (cnt == IDLY_TC) begin
            cnt     <= '0;
            fault_r <= 1'b1;
            state   <= FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FAULT: begin
          rst_out <= '1;
          ready   <= 1'b0;
        end
`endif
        RELEASE: begin
          if (cnt == HOLD_TC) begin
            // Stages release in index order, so a left shift clears the next one.
            cnt     <= '0;
            rst_out <= rst_out << 1;
            k       <= k + 1'b1;
            if (k == LAST_K) begin
              ready <= 1'b1;
              state <= RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state   <= WAIT_LOCK;
          rst_out <= '1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus queues timed output snapshots,
// a negedge monitor compares each observed output change against the queue head.
`timescale 1ns/1ps
module tb_rst_sequencer;

  localparam int NS   = 4;
  localparam int HOLD = 16;
  localparam int IDLY = 64;
`ifdef RST_SEQ_IDELAY_WAIT_EN
  localparam int IDW = 1;
`else
  localparam int IDW = 0;
`endif

  typedef struct {
    int         id;
    int         cyc;
    logic [3:0] rst;
    logic       rdy;
    logic       flt;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  logic       sys_clk    = 1'b0;
  logic       sys_rst_n  = 1'b1;
  logic       pll_lock   = 1'b1;
  logic       idelay_rdy = 1'b1;
  logic       sw_rst     = 1'b0;
  logic [3:0] rst_out;
  logic       ready;
  logic       idelay_fault;
  logic [7:0] lock_loss_cnt;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   ev_id  = 0;
  int   e_cnt  = 0;
  logic e_flt  = 1'b0;

  rst_sequencer #(
    .NUM_STAGES   (NS),
    .HOLD_CYCLES  (HOLD),
    .IDLY_TIMEOUT (IDLY)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .pll_lock      (pll_lock),
    .idelay_rdy    (idelay_rdy),
    .sw_rst        (sw_rst),
    .rst_out       (rst_out),
    .ready         (ready),
    .idelay_fault  (idelay_fault),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] r, input logic rd);
    exp_t e;
    e.id  = ev_id;
    e.cyc = c;
    e.rst = r;
    e.rdy = rd;
    e.flt = e_flt;
    e.cnt = 8'(e_cnt);
    exp_q.push_back(e);
    ev_id++;
  endtask

  // Stage k falls (k+1)*HOLD cycles after entering RELEASE at cycle r.
  task automatic push_seq(input int r);
    push(r + 1*HOLD, 4'hE, 1'b0);
    push(r + 2*HOLD, 4'hC, 1'b0);
    push(r + 3*HOLD, 4'h8, 1'b0);
    push(r + 4*HOLD, 4'h0, 1'b1);
  endtask

  // Returns 2 ns after the rising edge that brings cyc to c.
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  initial begin : monitor
    logic [14:0] prev;
    logic [14:0] snap;
    exp_t        e;
    prev = '1;
    forever begin
      @(negedge sys_clk);
      snap = {rst_out, ready, idelay_fault, lock_loss_cnt};
      if (snap != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc %0d got rst_out %h ready %b fault %b cnt %0d, required no change",
                   cyc, rst_out, ready, idelay_fault, lock_loss_cnt);
        end else begin
          e = exp_q.pop_front();
          if ((e.cyc >= 0 && e.cyc != cyc) || rst_out !== e.rst || ready !== e.rdy ||
              idelay_fault !== e.flt || lock_loss_cnt !== e.cnt) begin
            errors++;
            $display("FAIL ev%0d got cyc %0d rst_out %h ready %b fault %b cnt %0d, required cyc %0d rst_out %h ready %b fault %b cnt %0d",
                     e.id, cyc, rst_out, ready, idelay_fault, lock_loss_cnt,
                     e.cyc, e.rst, e.rdy, e.flt, e.cnt);
          end
        end
      end
      prev = snap;
    end
  end

  initial begin : stimulus
    int r, c, d, s, g, f;

    // Reset state.
    #1 sys_rst_n = 1'b0;
    push(-1, 4'hF, 1'b0);

    // Start-up with lock and idelay ready held from reset release.
    wait_to(3);
    sys_rst_n = 1'b1;
    r = 3 + 3 + IDW;
    push_seq(r);

    // sw_rst from RUN, then mid-sequence lock loss at cycle 40 and recovery.
    c = r + 70;
    wait_to(c);
    sw_rst = 1'b1;
    push(c + 1, 4'hF, 1'b0);
    wait_to(c + 1);
    sw_rst = 1'b0;
    r = c + 2 + IDW;
    push(r + HOLD, 4'hE, 1'b0);
    push(r + 2*HOLD, 4'hC, 1'b0);
    d = r + 40;
    wait_to(d);
    pll_lock = 1'b0;
    e_cnt = 1;
    push(d + 3, 4'hF, 1'b0);
    wait_to(d + 10);
    pll_lock = 1'b1;
    r = d + 13 + IDW;
    push_seq(r);

    // sw_rst in the same cycle that lock_s falls: counts once.
    d = r + 70;
    wait_to(d);
    pll_lock = 1'b0;
    wait_to(d + 2);
    sw_rst = 1'b1;
    e_cnt = 2;
    push(d + 3, 4'hF, 1'b0);
    wait_to(d + 3);
    sw_rst = 1'b0;
    wait_to(d + 10);
    pll_lock = 1'b1;
    r = d + 13 + IDW;

    // Lock loss on the stage-0 terminal count: no stage released.
    wait_to(r + HOLD - 3);
    pll_lock = 1'b0;
    e_cnt = 3;
    push(r + HOLD, 4'hF, 1'b0);
    wait_to(r + HOLD + 4);
    pll_lock = 1'b1;
    r = r + HOLD + 7 + IDW;
    push_seq(r);

`ifdef RST_SEQ_IDELAY_WAIT_EN
    // Idelay timeout, lock loss keeps the fault, sw_rst clears it.
    s = r + 70;
    wait_to(s);
    idelay_rdy = 1'b0;
    c = s + 5;
    wait_to(c);
    sw_rst = 1'b1;
    push(c + 1, 4'hF, 1'b0);
    wait_to(c + 1);
    sw_rst = 1'b0;
    e_flt = 1'b1;
    push(c + 2 + IDLY, 4'hF, 1'b0);
    g = c + 80;
    wait_to(g);
    pll_lock = 1'b0;
    e_cnt = 4;
    push(g + 3, 4'hF, 1'b0);
    wait_to(g + 6);
    pll_lock = 1'b1;
    f = g + 20;
    wait_to(f);
    sw_rst = 1'b1;
    idelay_rdy = 1'b1;
    e_flt = 1'b0;
    push(f + 1, 4'hF, 1'b0);
    wait_to(f + 1);
    sw_rst = 1'b0;
    r = f + 3;
    push_seq(r);
`endif

    // Saturation: 300 drop/restore pulses.
    d = r + 70;
    for (int i = 0; i < 300; i++) begin
      wait_to(d);
      pll_lock = 1'b0;
      if (e_cnt < 255) begin
        e_cnt++;
        push(d + 3, 4'hF, 1'b0);
      end
      wait_to(d + 5);
      pll_lock = 1'b1;
      d += 10;
    end
    r = (d - 10) + 8 + IDW;
    push_seq(r);

    // Asynchronous reset mid-RUN takes effect before the next edge.
    c = r + 70;
    wait_to(c);
    e_cnt = 0;
    e_flt = 1'b0;
    push(c, 4'hF, 1'b0);
    sys_rst_n = 1'b0;
    wait_to(c + 5);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge sys_clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_events got %0d left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
